l2req_arbiter_rr: RTL
=====================

Name: l2req_arbiter_rr

Overview:
- Parametrised successor to the fixed three-source L2 request arbiter/mux that serves the icache, dcache and store buffer.
- Arbitrates NUM_REQUESTERS L1-side request channels onto one registered L2 request port.
- Modes: round-robin or fixed priority. Per-channel enable masks. Source-ID tagging of each output packet.
- One output holding register, so throughput is one packet/cycle with a one-cycle request-to-L2 latency.

Parameters:
- NUM_REQUESTERS, 3, number of request channels; minimum 2, maximum 16.
- PACKET_WIDTH, 128, width in bits of one flattened L2 request packet.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- SRC_WIDTH, 2, width of the source index; must be at least ceil(log2(NUM_REQUESTERS)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQUESTERS  per-channel request present.
- req_packet  in  NUM_REQUESTERS*PACKET_WIDTH  packets; channel i occupies bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- req_ready  out  NUM_REQUESTERS  one-hot grant; channel i's packet is consumed this cycle.
- chan_enable  in  NUM_REQUESTERS  channel i takes part in arbitration only when 1.
- l2req_valid  out  1  output register holds a packet.
- l2req_packet  out  PACKET_WIDTH  registered packet.
- l2req_source  out  SRC_WIDTH  channel index of the registered packet.
- l2req_ready  in  1  L2 accepts the packet this cycle.
- grant_count_overflow  out  1  sticky flag: a per-channel grant counter wrapped.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset; every flop is cleared on a clk edge while reset=1.
- Reset values: l2req_valid=0, l2req_packet=0, l2req_source=0, rr_ptr=0, grant_count_overflow=0, all grant counters=0.
- req_ready is combinational and is forced to 0 while reset=1.
- Eligibility: eligible[i] = req_valid[i] & chan_enable[i].
- Load condition: load = ~l2req_valid | l2req_ready. The register is empty, or it is draining this cycle.
- Grant: when load=1 and any channel is eligible, exactly one req_ready bit is asserted, for the winner w. With load=0, req_ready is all zeros.
- Round-robin (PRIORITY_MODE=0): w is the first eligible index scanning from rr_ptr upward, wrapping from NUM_REQUESTERS-1 back to 0.
- Fixed priority (PRIORITY_MODE=1): w is the lowest eligible index; rr_ptr is ignored.
- Register update on the clk edge:
  - load=1 and a winner exists: l2req_packet<=packet[w], l2req_source<=w, l2req_valid<=1, rr_ptr<=(w+1) mod NUM_REQUESTERS.
  - load=1 and no winner: l2req_valid<=0; packet, source and rr_ptr hold.
  - load=0: all registers hold, giving a stable payload while stalled.
- Latency and throughput: a grant at edge t appears on l2req_* after edge t+1. With l2req_ready held at 1, a new packet is issued every cycle.
- Handshake rules:
  - A requester must hold req_valid and req_packet stable until it sees req_ready.
  - The arbiter never drops a granted packet.
  - The arbiter never issues a packet twice.
- Simultaneous drain and grant in one cycle: the old packet is accepted by L2 and the new packet is loaded at the same edge, with no bubble.
- chan_enable: deasserting it mid-stall does not affect a packet already held in the register.
- Grant counters: each channel has an 8-bit count of grants. When a counter wraps from 255 to 0, grant_count_overflow is set and stays set until reset.
- Reset during operation: a held packet is discarded (l2req_valid=0 on the next cycle). Requesters must re-present their requests after reset.

Test Plan:
- Reset with all channels valid: req_ready=000 and l2req_valid=0 during reset. On the first post-reset cycle with l2req_ready=1, req_ready=001; on the next cycle l2req_source=0.
- Round-robin with NUM_REQUESTERS=3, all valid, l2req_ready=1 continuously: l2req_source sequence 0,1,2,0,1,2 with no bubbles.
- Backpressure: hold l2req_ready=0 for 4 cycles with ch1 holding packet 0xA5. l2req_packet stays 0xA5 and req_ready=000 throughout. When l2req_ready rises, the next winner loads in the same edge.
- PRIORITY_MODE=1 with ch0 and ch2 valid: ch0 wins every cycle and ch2 starves. Deasserting chan_enable[0] lets ch2 win on the next cycle.
- Sparse requests with only ch2 valid under round-robin from rr_ptr=0: ch2 is granted and rr_ptr becomes 0. Then ch0 and ch2 valid together: ch0 wins.
- Counter wrap with ch1 sole requester for 256 grants: grant_count_overflow goes to 1 after the 256th grant and remains 1 until reset.

Source files
------------

// File: rtl/l2req_arbiter_rr.sv
// Arbitrates NUM_REQUESTERS request channels onto one registered L2 request port.
// 1-cycle grant-to-output latency; grants only while the output register is empty or draining.
module l2req_arbiter_rr #(
  parameter int NUM_REQUESTERS = 3,
  parameter int PACKET_WIDTH   = 128,
  parameter int PRIORITY_MODE  = 0,
  parameter int SRC_WIDTH      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  input  logic [NUM_REQUESTERS*PACKET_WIDTH-1:0] req_packet,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  input  logic [NUM_REQUESTERS-1:0]              chan_enable,
  output logic                                   l2req_valid,
  output logic [PACKET_WIDTH-1:0]                l2req_packet,
  output logic [SRC_WIDTH-1:0]                   l2req_source,
  input  logic                                   l2req_ready,
  output logic                                   grant_count_overflow
);

  logic [NUM_REQUESTERS-1:0] eligible;
  logic                      load;
  logic                      grant;
  logic                      any_hi, any_lo;
  int                        ptr, hi_idx, lo_idx, win_idx;
  logic [PACKET_WIDTH-1:0]   win_pkt;

  logic                      valid_q, valid_d;
  logic [PACKET_WIDTH-1:0]   pkt_q, pkt_d;
  logic [SRC_WIDTH-1:0]      src_q, src_d;
  logic [SRC_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic                      ovf_q, ovf_d;
  logic [7:0]                gcnt_q [NUM_REQUESTERS];
  logic [7:0]                gcnt_d [NUM_REQUESTERS];

  // Two passes: lowest eligible at or above the pointer, else lowest eligible overall.
  always_comb begin
    eligible = req_valid & chan_enable;
    load     = ~valid_q | l2req_ready;
    ptr      = (PRIORITY_MODE == 1) ? 0 : int'(rr_ptr_q);
    any_hi   = 1'b0;
    any_lo   = 1'b0;
    hi_idx   = 0;
    lo_idx   = 0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        any_lo = 1'b1;
        lo_idx = i;
        if (i >= ptr) begin
          any_hi = 1'b1;
          hi_idx = i;
        end
      end
    end
    win_idx   = any_hi ? hi_idx : lo_idx;
    grant     = ~reset & load & any_lo;
    win_pkt   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (win_idx == i) win_pkt = req_packet[i*PACKET_WIDTH +: PACKET_WIDTH];
      req_ready[i] = grant && (win_idx == i);
    end
  end

  always_comb begin
    valid_d  = valid_q;
    pkt_d    = pkt_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    ovf_d    = ovf_q;
    gcnt_d   = gcnt_q;
    if (load) begin
      valid_d = grant;
      if (grant) begin
        pkt_d    = win_pkt;
        src_d    = SRC_WIDTH'(win_idx);
        rr_ptr_d = (win_idx == NUM_REQUESTERS - 1) ? '0 : SRC_WIDTH'(win_idx + 1);
      end
    end
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (req_ready[i]) begin
        gcnt_d[i] = gcnt_q[i] + 8'd1;
        if (gcnt_q[i] == 8'hFF) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pkt_q    <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NUM_REQUESTERS; i++) gcnt_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      pkt_q    <= pkt_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < NUM_REQUESTERS; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end

  assign l2req_valid          = valid_q;
  assign l2req_packet         = pkt_q;
  assign l2req_source         = src_q;
  assign grant_count_overflow = ovf_q;

endmodule
